// File: rtl/mips_pkg.sv
// Shared types for the writeback port arbiter: arbitration states and the
// register-file write request record.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  // Register 0 is hardwired, so a request to it consumes a slot but never writes.
  function automatic logic rf_writes(input wb_req_t r);
    return r.reg_addr != '0;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline/secondary units (master) and the
// register-file writeback arbiter (slave).
interface wb_port_arbiter_if;
  import mips_pkg::*;

  logic                  reg_write;
  logic [REG_ADDR_W-1:0] write_register;
  logic [DATA_W-1:0]     write_data_reg;
  logic                  sec_valid;
  logic                  sec_ready;
  logic [REG_ADDR_W-1:0] sec_reg;
  logic [DATA_W-1:0]     sec_data;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  stall_req;
  logic [1:0]            pend_count;

  modport master (
    output reg_write, write_register, write_data_reg,
    output sec_valid, sec_reg, sec_data,
    input  sec_ready, rf_we, rf_waddr, rf_wdata, stall_req, pend_count
  );

  modport slave (
    input  reg_write, write_register, write_data_reg,
    input  sec_valid, sec_reg, sec_data,
    output sec_ready, rf_we, rf_waddr, rf_wdata, stall_req, pend_count
  );

endinterface

// File: rtl/wb_sec_fifo.sv
// Two-entry in-order buffer for secondary writes; each entry carries a valid
// bit so a newer pipeline write can cancel it without disturbing order.
module wb_sec_fifo
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_req_t               push_req,
  input  logic                  pop,
  input  logic                  inv_en,
  input  logic [REG_ADDR_W-1:0] inv_addr,
  output wb_req_t               head,
  output logic                  head_vld,
  output logic [1:0]            count
);

  wb_req_t    mem [2];
  logic [1:0] vld;
  logic       rd_ptr;
  logic       wr_ptr;

  assign head     = mem[rd_ptr];
  assign head_vld = vld[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  // Invalidation looks only at stored entries; the slot being pushed this
  // cycle is re-marked valid afterwards, so it survives a same-cycle match.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      vld    <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (inv_en && vld[i] && (mem[i].reg_addr == inv_addr)) vld[i] <= 1'b0;
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the WB-stage pipeline
// write and buffered secondary (mult/div, HI/LO) writes, with anti-starvation.
module wb_port_arbiter
  import mips_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input logic              clk,
  input logic              rst_n,
  wb_port_arbiter_if.slave bus
);

  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);
  localparam logic [2:0] LIMIT    = 3'(STARVE_LIMIT);

  arb_state_t            state_q, state_d;
  logic [2:0]            starve_q, starve_d, starve_inc;
  logic                  stall_q;
  logic [1:0]            count;
  wb_req_t               head, grant_req, sec_req;
  logic                  head_vld;
  logic                  push, pop, pipe_grant, grant_vld;
  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0]     rf_wdata_q;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  assign sec_req    = '{reg_addr: bus.sec_reg, data: bus.sec_data};
  assign push       = bus.sec_valid && bus.sec_ready;
  assign starve_inc = sat_inc(starve_q);

  wb_sec_fifo u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_req (sec_req),
    .pop      (pop),
    .inv_en   (pipe_grant),
    .inv_addr (bus.write_register),
    .head     (head),
    .head_vld (head_vld),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= 3'd0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      stall_q  <= (state_d == FORCE);
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        starve_d = 3'd0;
        if (push) state_d = PEND;
      end
      PEND: begin
        if (pop) begin
          starve_d = 3'd0;
          if ((count == 2'd1) && !push) state_d = IDLE;
        end else if (pipe_grant) begin
          starve_d = starve_inc;
          if (starve_inc >= LIMIT) state_d = FORCE;
        end
      end
      FORCE: begin
        starve_d = 3'd0;
        state_d  = ((count == 2'd1) && !push) ? IDLE : PEND;
      end
      default: begin
        state_d  = IDLE;
        starve_d = 3'd0;
      end
    endcase
  end

  // A cancelled head is still popped, but it is not a grant: outputs hold.
  always_comb begin
    pipe_grant = !stall_q && bus.reg_write;
    pop        = !pipe_grant && (count != 2'd0);
    grant_vld  = 1'b0;
    grant_req  = '0;
    if (pipe_grant) begin
      grant_vld = 1'b1;
      grant_req = '{reg_addr: bus.write_register, data: bus.write_data_reg};
    end else if (pop && head_vld) begin
      grant_vld = 1'b1;
      grant_req = head;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= grant_vld && rf_writes(grant_req);
      if (grant_vld) begin
        rf_waddr_q <= grant_req.reg_addr;
        rf_wdata_q <= grant_req.data;
      end
    end
  end

  assign bus.sec_ready  = (count < FULL_CNT);
  assign bus.pend_count = count;
  assign bus.stall_req  = stall_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, SHALL set the consecutive lost-arbitration cycles before a forced drain (legal range 1..7).
REQ-002 Parameter FIFO_DEPTH, default 2, SHALL set the secondary-request buffer depth (fixed at 2 for this revision).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 reg_write  input  1  SHALL be the pipeline writeback request (from WB stage).
REQ-006 write_register  input  5  SHALL be the pipeline destination register.
REQ-007 write_data_reg  input  32  SHALL be the pipeline write data.
REQ-008 sec_valid  input  1  SHALL be the secondary (mult/div, HI/LO move) write request.
REQ-009 sec_ready  output  1  SHALL indicate the secondary request is accepted this cycle.
REQ-010 sec_reg  input  5  SHALL be the secondary destination register.
REQ-011 sec_data  input  32  SHALL be the secondary write data.
REQ-012 rf_we  output  1  SHALL be the registered register-file write enable.
REQ-013 rf_waddr  output  5  SHALL be the registered register-file write address.
REQ-014 rf_wdata  output  32  SHALL be the registered register-file write data.
REQ-015 stall_req  output  1  SHALL request the pipeline hold its WB stage (reg_write treated as absent while high).
REQ-016 pend_count  output  2  SHALL report buffered secondary entries (0..2).

Function
REQ-017 Secondary handshake: transfer occurs when sec_valid && sec_ready; sec_ready = (pend_count < FIFO_DEPTH), from registered state only.
REQ-018 Accepted secondary writes SHALL enter an in-order FIFO; push and pop in the same cycle SHALL both take effect, count unchanged.
REQ-019 Arbitration per cycle: if stall_req=0 and reg_write=1, the pipeline write SHALL be granted; otherwise the FIFO head (if any) SHALL be granted and popped.
REQ-020 Granted write SHALL appear on rf_we/rf_waddr/rf_wdata exactly one cycle later; no grant -> rf_we=0 next cycle, rf_waddr/rf_wdata hold.
REQ-021 Writes to register 0 SHALL be granted/popped normally but produce rf_we=0.
REQ-022 Ordering: when a pipeline write is granted, every buffered entry with equal destination SHALL be invalidated (popped without write when reaching head); an entry pushed in the same cycle is not invalidated.
REQ-023 State machine: IDLE (FIFO empty) -> PEND on push; PEND -> IDLE when last entry pops; PEND -> FORCE when starve counter reaches STARVE_LIMIT; FORCE -> PEND/IDLE after one head pop.
REQ-024 Starve counter (3 bits) SHALL increment each PEND cycle the head loses to the pipeline, clear on any pop or in IDLE, saturate at 7.
REQ-025 stall_req SHALL be high exactly in FORCE; it is a registered output.
REQ-026 Empty FIFO: no pop, head data ignored; full FIFO: sec_ready=0, sec_valid ignored.
REQ-027 pend_count SHALL reflect post-update occupancy, registered.

Reset
REQ-028 On rst_n=0 at posedge clk: FIFO emptied, state IDLE, starve counter 0, rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0, pend_count=0; sec_ready=1 the cycle after release.
REQ-029 Reset mid-operation SHALL discard all buffered entries without issuing writes.

Structure
REQ-030 Shared package mips_pkg SHALL hold the arb_state_t enum (IDLE, PEND, FORCE), REG_ADDR_W=5, DATA_W=32, and wb_req_t struct {reg, data}.
REQ-031 One sub-module wb_sec_fifo (2-entry, valid bits per entry for invalidation) SHALL be instantiated; arbitration/FSM in the top.

Verification
REQ-032 Reset then sec_valid, sec_reg=8, sec_data=0xDEAD_BEEF, reg_write=0 -> next cycle pop granted, following cycle rf_we=1, rf_waddr=8, rf_wdata=0xDEADBEEF.
REQ-033 Push two entries, hold sec_valid -> sec_ready=0, pend_count=2, third request not accepted until a pop.
REQ-034 FIFO entry reg 5 pending, reg_write=1 continuously (reg 9) -> after 4 lost cycles stall_req=1 for one cycle, reg 5 written, then pipeline resumes.
REQ-035 FIFO entry reg 3 data 0x11, then pipeline write reg 3 data 0x22 granted -> only 0x22 written to reg 3; entry dropped, pend_count returns 0.
REQ-036 Secondary write to reg 0 -> popped, rf_we stays 0.
REQ-037 Two entries buffered, rst_n=0 one cycle -> pend_count=0, rf_we=0, no subsequent writes.
